// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared 256x8
// data memory. The arbiter sits on the slave modport; the requesters and
// the memory model sit on the master modport.
interface dmem_arbiter_if;
  logic       p0_req;
  logic       p0_we;
  logic [7:0] p0_addr;
  logic [7:0] p0_wdata;
  logic       p0_gnt;
  logic       p0_rvalid;
  logic [7:0] p0_rdata;

  logic       p1_req;
  logic       p1_we;
  logic [7:0] p1_addr;
  logic [7:0] p1_wdata;
  logic       p1_gnt;
  logic       p1_rvalid;
  logic [7:0] p1_rdata;

  logic       mem_dw;
  logic [7:0] mem_a;
  logic [7:0] mem_d;
  logic [7:0] mem_rd;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_dw, mem_a, mem_d,
    input  mem_rd
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_dw, mem_a, mem_d,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port 256x8 data memory.
// Port 0 = core load/store unit, port 1 = DMA/debug loader.
// One access is granted per cycle; read data returns registered one cycle
// after the grant. ARB_MODE 0 = round-robin, 1 = port 0 priority with a
// starvation guard that forces port 1 through after MAX_WAIT denials.
module dmem_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic       r_last_winner;  // 1 = port 1 won the most recent grant
  logic [3:0] r_wait_cnt;
  logic       r_p0_rvalid;
  logic       r_p1_rvalid;
  logic [7:0] r_p0_rdata;
  logic [7:0] r_p1_rdata;

  logic       w_gnt0;
  logic       w_gnt1;

  // Winner selection; grants are held off entirely while in reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst) begin
      if (bus.p0_req && bus.p1_req) begin
        if (ARB_MODE == 0) begin
          if (r_last_winner) w_gnt0 = 1'b1;
          else               w_gnt1 = 1'b1;
        end else begin
          if (r_wait_cnt == LP_MAX_WAIT) w_gnt1 = 1'b1;
          else                           w_gnt0 = 1'b1;
        end
      end else begin
        w_gnt0 = bus.p0_req;
        w_gnt1 = bus.p1_req;
      end
    end
  end

  // Memory drive and port outputs; registered read results are masked in
  // reset so a read granted just before reset never shows up as valid.
  always_comb begin
    bus.p0_gnt    = w_gnt0;
    bus.p1_gnt    = w_gnt1;
    bus.mem_dw    = (w_gnt0 & bus.p0_we) | (w_gnt1 & bus.p1_we);
    bus.mem_a     = 8'h00;
    bus.mem_d     = 8'h00;
    if (w_gnt1) begin
      bus.mem_a = bus.p1_addr;
      bus.mem_d = bus.p1_wdata;
    end else if (w_gnt0) begin
      bus.mem_a = bus.p0_addr;
      bus.mem_d = bus.p0_wdata;
    end
    bus.p0_rvalid = r_p0_rvalid & ~rst;
    bus.p1_rvalid = r_p1_rvalid & ~rst;
    bus.p0_rdata  = rst ? 8'h00 : r_p0_rdata;
    bus.p1_rdata  = rst ? 8'h00 : r_p1_rdata;
  end

  // Read-data capture, last-winner tracking and port 1 starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_rvalid   <= 1'b0;
      r_p1_rvalid   <= 1'b0;
      r_p0_rdata    <= 8'h00;
      r_p1_rdata    <= 8'h00;
      r_last_winner <= 1'b1;
      r_wait_cnt    <= 4'd0;
    end else begin
      r_p0_rvalid <= w_gnt0 & ~bus.p0_we;
      r_p1_rvalid <= w_gnt1 & ~bus.p1_we;
      if (w_gnt0 && !bus.p0_we) r_p0_rdata <= bus.mem_rd;
      if (w_gnt1 && !bus.p1_we) r_p1_rdata <= bus.mem_rd;
      if (w_gnt0 || w_gnt1) r_last_winner <= w_gnt1;
      if (ARB_MODE == 1 && bus.p1_req && !w_gnt1) begin
        if (r_wait_cnt != LP_MAX_WAIT) r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance driven from a
// vector table, and a fixed-priority instance exercised by a hand sequence.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_rr;
  logic rst_fp;
  logic mem_clr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus_rr ();
  dmem_arbiter_if bus_fp ();

  dmem_arbiter #(.ARB_MODE(0), .MAX_WAIT(4)) u_rr (.clk(clk), .rst(rst_rr), .bus(bus_rr));
  dmem_arbiter #(.ARB_MODE(1), .MAX_WAIT(4)) u_fp (.clk(clk), .rst(rst_fp), .bus(bus_fp));

  // Memory models: async read, write at the rising edge.
  logic [7:0] mem_rr [256];
  logic [7:0] mem_fp [256];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_rr[i] <= 8'h00;
        mem_fp[i] <= 8'h00;
      end
    end else begin
      if (bus_rr.mem_dw) mem_rr[bus_rr.mem_a] <= bus_rr.mem_d;
      if (bus_fp.mem_dw) mem_fp[bus_fp.mem_a] <= bus_fp.mem_d;
    end
  end

  assign bus_rr.mem_rd = mem_rr[bus_rr.mem_a];
  assign bus_fp.mem_rd = mem_fp[bus_fp.mem_a];

  typedef struct {
    logic       rst;
    logic       q0, w0;
    logic [7:0] a0, d0;
    logic       q1, w1;
    logic [7:0] a1, d1;
    logic       g0, g1, dw;
    logic [7:0] ea, ed;
    logic       rv0;
    logic [7:0] rd0;
    logic       rv1;
    logic [7:0] rd1;
  } vec_t;

  vec_t vecs[$];

  task automatic av(input logic r,
                    input logic q0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                    input logic q1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                    input logic g0, input logic g1, input logic dw,
                    input logic [7:0] ea, input logic [7:0] ed,
                    input logic rv0, input logic [7:0] rd0,
                    input logic rv1, input logic [7:0] rd1);
    vec_t v;
    v.rst = r;  v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1;  v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0;  v.g1 = g1; v.dw = dw; v.ea = ea; v.ed = ed;
    v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d actual=%02h required=%02h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // idle (reset)
    av(1, 1,1,8'h10,8'hFF, 1,1,8'h20,8'hEE,  0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00); // 0
    av(1, 1,1,8'h10,8'hFF, 1,1,8'h20,8'hEE,  0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00); // 1
    av(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00); // 2
    // single-port write then read
    av(0, 1,1,8'h10,8'hA5, 0,0,8'h00,8'h00,  1,0,1,8'h10,8'hA5, 0,8'h00, 0,8'h00); // 3
    av(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00,  1,0,0,8'h10,8'h00, 0,8'h00, 0,8'h00); // 4
    av(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 1,8'hA5, 0,8'h00); // 5
    av(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 0,8'hA5, 0,8'h00); // 6
    // preload for round-robin, then reset
    av(0, 1,1,8'h01,8'h11, 0,0,8'h00,8'h00,  1,0,1,8'h01,8'h11, 0,8'hA5, 0,8'h00); // 7
    av(0, 0,0,8'h00,8'h00, 1,1,8'h02,8'h22,  0,1,1,8'h02,8'h22, 0,8'hA5, 0,8'h00); // 8
    av(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00); // 9
    // round-robin, both reading
    av(0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00,  1,0,0,8'h01,8'h00, 0,8'h00, 0,8'h00); // 10
    av(0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00,  0,1,0,8'h02,8'h00, 1,8'h11, 0,8'h00); // 11
    av(0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00,  1,0,0,8'h01,8'h00, 0,8'h11, 1,8'h22); // 12
    av(0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00,  0,1,0,8'h02,8'h00, 1,8'h11, 0,8'h22); // 13
    av(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 0,8'h11, 1,8'h22); // 14
    // cross-port ordering at address extremes
    av(0, 0,0,8'h00,8'h00, 1,1,8'hFF,8'h3C,  0,1,1,8'hFF,8'h3C, 0,8'h11, 0,8'h22); // 15
    av(0, 1,0,8'hFF,8'h00, 0,0,8'h00,8'h00,  1,0,0,8'hFF,8'h00, 0,8'h11, 0,8'h22); // 16
    av(0, 0,0,8'h00,8'h00, 1,1,8'h00,8'h5A,  0,1,1,8'h00,8'h5A, 1,8'h3C, 0,8'h22); // 17
    av(0, 1,0,8'h00,8'h00, 0,0,8'h00,8'h00,  1,0,0,8'h00,8'h00, 0,8'h3C, 0,8'h22); // 18
    av(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 1,8'h5A, 0,8'h22); // 19
    // same-address collision, loser retries, withdrawn request
    av(0, 1,1,8'h40,8'h66, 1,0,8'h40,8'h00,  0,1,0,8'h40,8'h00, 0,8'h5A, 0,8'h22); // 20
    av(0, 1,1,8'h40,8'h66, 0,0,8'h00,8'h00,  1,0,1,8'h40,8'h66, 0,8'h5A, 1,8'h00); // 21
    av(0, 0,0,8'h00,8'h00, 1,0,8'h40,8'h00,  0,1,0,8'h40,8'h00, 0,8'h5A, 0,8'h00); // 22
    av(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 0,8'h5A, 1,8'h66); // 23
    // reset mid-access
    av(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00,  1,0,0,8'h10,8'h00, 0,8'h5A, 0,8'h66); // 24
    av(1, 0,0,8'h00,8'h00, 1,1,8'h10,8'h77,  0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00); // 25
    av(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 0,8'h00, 0,8'h00); // 26
    av(0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00,  1,0,0,8'h10,8'h00, 0,8'h00, 0,8'h00); // 27
    av(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 1,8'hA5, 0,8'h00); // 28

    mem_clr = 1'b1;
    rst_rr  = 1'b1;
    rst_fp  = 1'b1;
    bus_rr.p0_req = 1'b0; bus_rr.p0_we = 1'b0; bus_rr.p0_addr = 8'h00; bus_rr.p0_wdata = 8'h00;
    bus_rr.p1_req = 1'b0; bus_rr.p1_we = 1'b0; bus_rr.p1_addr = 8'h00; bus_rr.p1_wdata = 8'h00;
    bus_fp.p0_req = 1'b0; bus_fp.p0_we = 1'b0; bus_fp.p0_addr = 8'h00; bus_fp.p0_wdata = 8'h00;
    bus_fp.p1_req = 1'b0; bus_fp.p1_we = 1'b0; bus_fp.p1_addr = 8'h00; bus_fp.p1_wdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    mem_clr = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_rr        = vecs[i].rst;
      bus_rr.p0_req = vecs[i].q0; bus_rr.p0_we = vecs[i].w0;
      bus_rr.p0_addr = vecs[i].a0; bus_rr.p0_wdata = vecs[i].d0;
      bus_rr.p1_req = vecs[i].q1; bus_rr.p1_we = vecs[i].w1;
      bus_rr.p1_addr = vecs[i].a1; bus_rr.p1_wdata = vecs[i].d1;
      #1;
      chk("p0_gnt",    i, 8'(bus_rr.p0_gnt),    8'(vecs[i].g0));
      chk("p1_gnt",    i, 8'(bus_rr.p1_gnt),    8'(vecs[i].g1));
      chk("mem_dw",    i, 8'(bus_rr.mem_dw),    8'(vecs[i].dw));
      chk("mem_a",     i, bus_rr.mem_a,         vecs[i].ea);
      chk("mem_d",     i, bus_rr.mem_d,         vecs[i].ed);
      chk("p0_rvalid", i, 8'(bus_rr.p0_rvalid), 8'(vecs[i].rv0));
      chk("p0_rdata",  i, bus_rr.p0_rdata,      vecs[i].rd0);
      chk("p1_rvalid", i, 8'(bus_rr.p1_rvalid), 8'(vecs[i].rv1));
      chk("p1_rdata",  i, bus_rr.p1_rdata,      vecs[i].rd1);
      chk("rr_wait_cnt", i, 8'(u_rr.r_wait_cnt), 8'h00);
    end

    // Starvation guard: both request continuously, p1 forced through every 5th cycle.
    @(negedge clk);
    mem_fp[8'h02] = 8'h2B;
    rst_fp = 1'b1;
    @(negedge clk);
    rst_fp = 1'b0;
    bus_fp.p0_req = 1'b1; bus_fp.p0_we = 1'b0; bus_fp.p0_addr = 8'h01;
    bus_fp.p1_req = 1'b1; bus_fp.p1_we = 1'b0; bus_fp.p1_addr = 8'h02;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("fp_wait_cnt", 100 + c, 8'(u_fp.r_wait_cnt), 8'(c % 5));
      chk("fp_p0_gnt",   100 + c, 8'(bus_fp.p0_gnt),   8'((c % 5) != 4));
      chk("fp_p1_gnt",   100 + c, 8'(bus_fp.p1_gnt),   8'((c % 5) == 4));
      chk("fp_p1_rvalid", 100 + c, 8'(bus_fp.p1_rvalid), 8'(c > 0 && ((c - 1) % 5) == 4));
      if (c == 5) chk("fp_p1_rdata", 100 + c, bus_fp.p1_rdata, 8'h2B);
    end

    bus_fp.p0_req = 1'b0; bus_fp.p1_req = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
